// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused over WIDTH clocks,
// LSB first, with the carry threaded through a register.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] acc_nx;

    always_comb begin
        s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
        c_bit  = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        // new sum bit enters at the MSB; after WIDTH shifts bit 0 lines up
        acc_nx = (acc >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    acc   <= acc_nx;
                    carry <= c_bit;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= acc_nx;
                        cout  <= c_bit;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 and WIDTH=2 instances checked every
// cycle against a transaction-timing model, plus directed literal results.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       st8, ci8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       st2, ci2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    int vectors = 0;
    int miscompares = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .cin(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .cin(ci2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: t = cycles since accept (-1 when idle); result is a+b+cin.
    typedef struct {
        int t;
        int res;
        int esum;
        int ecout;
    } mdl_t;
    mdl_t m[2];

    always @(posedge clk or negedge rst_n) begin : model
        int w, r;
        logic s;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 8 : 2;
            s = (k == 0) ? st8 : st2;
            r = (k == 0) ? int'(a8) + int'(b8) + int'(ci8)
                         : int'(a2) + int'(b2) + int'(ci2);
            if (!rst_n) begin
                m[k].t = -1; m[k].res = 0; m[k].esum = 0; m[k].ecout = 0;
            end else if (m[k].t < 0) begin
                if (s) begin
                    m[k].t = 0;
                    m[k].res = r;
                end
            end else begin
                m[k].t++;
                if (m[k].t == w) begin
                    m[k].esum  = m[k].res % (1 << w);
                    m[k].ecout = (m[k].res >> w) & 1;
                end else if (m[k].t == w + 1) begin
                    m[k].t = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy8", busy8, int'(m[0].t >= 0 && m[0].t < 8));
        chk("done8", done8, int'(m[0].t == 8));
        chk("sum8",  sum8,  m[0].esum);
        chk("cout8", cout8, m[0].ecout);
        chk("busy2", busy2, int'(m[1].t >= 0 && m[1].t < 2));
        chk("done2", done2, int'(m[1].t == 2));
        chk("sum2",  sum2,  m[1].esum);
        chk("cout2", cout2, m[1].ecout);
    end

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                       input logic [7:0] es, input logic ec);
        int n, nb;
        st8 = 1'b1; a8 = x; b8 = y; ci8 = c;
        @(negedge clk);
        st8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        n = 1;
        nb = int'(busy8);
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
            nb += int'(busy8);
        end
        chk("latency8", n, 9);
        chk("busycycles8", nb, 8);
        chk("sum8_lit", sum8, es);
        chk("cout8_lit", cout8, ec);
        @(negedge clk);
        chk("donefall8", done8, 0);
        chk("busyafter8", busy8, 0);
    endtask

    task automatic op2(input int x, input int y, input int c);
        int n, r;
        r = x + y + c;
        st2 = 1'b1; a2 = 2'(x); b2 = 2'(y); ci2 = c[0];
        @(negedge clk);
        st2 = 1'b0; a2 = ~a2; b2 = ~b2; ci2 = ~ci2;
        n = 1;
        while (!done2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency2", n, 3);
        chk("result2", int'({cout2, sum2}), r);
        @(negedge clk);
    endtask

    initial begin
        int n, first, second;
        rst_n = 1'b0;
        st8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'b1;
        st2 = 1'b1; a2 = 2'($urandom); b2 = 2'($urandom); ci2 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum",  sum8,  0);
        chk("rst_cout", cout8, 0);
        st8 = 1'b0; st2 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

        // Back-to-back requests with start held high.
        st8 = 1'b1; a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0;
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h04;
        first = -1; second = -1;
        for (n = 1; n < 40; n++) begin
            if (done8) begin
                if (first < 0) begin
                    first = n;
                    chk("cont_sum1", sum8, 8'h30);
                end else begin
                    second = n;
                    chk("cont_sum2", sum8, 8'h07);
                    break;
                end
            end else if (first >= 0 && busy8) begin
                chk("cont_hold", sum8, 8'h30);
            end
            @(negedge clk);
        end
        st8 = 1'b0;
        chk("cont_first", first, 9);
        chk("cont_spacing", second - first, 10);
        repeat (2) @(negedge clk);

        // Abort mid-operation with an asynchronous reset between edges.
        st8 = 1'b1; a8 = 8'h55; b8 = 8'h55; ci8 = 1'b0;
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_sum", sum8, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) n++;
        end
        chk("abort_nodone", n, 0);
        chk("abort_sum_after", sum8, 0);
        op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int c = 0; c < 2; c++)
                    op2(x, y, c);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that schedules one 1-bit full-adder cell across two WIDTH-bit operands, least significant bit first, one bit per clock. It captures the operands on a start request and threads the carry between cycles through a register. It returns a WIDTH-bit sum and a carry-out with a one-cycle done pulse. It sits next to the combinational adder cells as the area-minimal alternative to a WIDTH-bit ripple adder.

## Interface

Parameters:
- WIDTH, 8: operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the single clock of the block.
- rst_n  input  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronous to clk.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accept edge.
- b  input  WIDTH  operand B; captured on the accept edge.
- cin  input  1  carry-in; captured on the accept edge.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse; the new sum/cout are valid from this cycle.
- sum  output  WIDTH  registered result; holds the last completed result.
- cout  output  1  registered carry-out of the MSB; holds with sum.

## Operation

- States: IDLE, RUN, DONE. The state encoding is internal.
- IDLE:
  - On a clk edge with start=1: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, then go to RUN. This edge is the accept edge.
  - With start=0: stay in IDLE.
- RUN, on each edge:
  - Compute bit s = a_sh[0] ^ b_sh[0] ^ carry.
  - Compute c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0])).
  - Shift a_sh and b_sh right by 1.
  - Shift s into the MSB of the internal accumulator acc, shifting acc right.
  - Update carry<=c and cnt<=cnt+1.
- When cnt==WIDTH-1 on an edge:
  - Process the final bit as above.
  - Load sum<={s, acc[WIDTH-1:1]} and cout<=c.
  - Go to DONE.
- DONE: done=1 for exactly one cycle; the next edge goes to IDLE unconditionally.
- start is ignored in RUN and DONE. A request held high is accepted on the first edge seen in IDLE.
- Changes to a, b or cin after the accept edge have no effect on the result in progress.
- sum/cout change only when DONE is entered, never during RUN. They hold the previous result throughout a new operation.
- cnt is $clog2(WIDTH)+1 bits wide, so WIDTH-1 is representable without wrap. The result is arithmetically a + b + cin, modulo 2^WIDTH, with cout as bit WIDTH.
- busy = (state==RUN); done = (state==DONE). Both are decoded from registered state, so there is no combinational path from inputs to outputs.

## Timing

- Reset values, forced asynchronously while rst_n=0:
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - a_sh, b_sh, acc, carry and cnt all 0.
- Latency: with the accept edge at edge 0, the last bit is processed at edge WIDTH. done is high in the cycle after edge WIDTH, with sum/cout valid from the same cycle.
- busy is high from after edge 0 through edge WIDTH, i.e. exactly WIDTH cycles.
- The FSM returns to IDLE at edge WIDTH+1. The earliest next accept is edge WIDTH+2, so continuous start gives one result per WIDTH+2 cycles.
- Reset asserted mid-RUN or in DONE: the operation is aborted, no done pulse is produced, and the outputs go to reset values. After release, the block idles until start is seen.
- start=1 on the same edge that rst_n deasserts: not accepted. The first possible accept is the following edge.

## Test plan

- Reset: hold rst_n=0 with start=1 and random a/b → busy=0, done=0, sum=0x00, cout=0. Pull rst_n low asynchronously, between edges, → outputs clear before the next edge.
- WIDTH=8, a=0xFF, b=0x01, cin=0, start for 1 cycle → busy high 8 cycles, done high in the cycle after edge 8, sum=0x00, cout=1. Then done falls and busy stays 0.
- Exhaustive single-bit stepping with WIDTH=2: all 32 combinations of a, b, cin → {cout,sum} equals a+b+cin every time. This covers every full-adder cell input pattern for both bit positions.
- a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1. a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0. Change a/b to 0x00 at edge 3 → result unchanged.
- start held high continuously, operands 0x10+0x20 then 0x03+0x04 → done pulses spaced exactly 10 cycles apart with sum=0x30 then 0x07. sum holds 0x30 throughout the second RUN.
- Reset mid-operation: accept 0x55+0x55, assert rst_n=0 at cycle 4 and release it → no done pulse, sum=0x00. A new start with 0x01+0x01 yields sum=0x02, cout=0, done 8 cycles after accept.
